memory_bus_arbiter: RTL and testbench

//  Shares one MemoryBus slave port (e.g. a MemorySlave bridge or BRAM controller) between NUM_MASTERS requesters.

---
 rtl/memory_bus_arbiter_if.sv | 45 ++++
 rtl/memory_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_bus_arbiter_if.sv
// rtl/memory_bus_arbiter_if.sv - request/response bundle between the masters, the arbiter and the shared slave
interface memory_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 8
);
    logic [NUM_MASTERS-1:0]            m_ms_valid;
    logic [NUM_MASTERS-1:0]            m_ms_taken;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ms_address;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_ms_data;
    logic [NUM_MASTERS-1:0]            m_ms_write;
    logic [NUM_MASTERS-1:0]            m_sm_valid;
    logic [NUM_MASTERS-1:0]            m_sm_taken;
    logic [DATA_WIDTH-1:0]             m_sm_data;
    logic                              s_ms_valid;
    logic                              s_ms_taken;
    logic [ADDR_WIDTH-1:0]             s_ms_address;
    logic [DATA_WIDTH-1:0]             s_ms_data;
    logic                              s_ms_write;
    logic [ID_WIDTH-1:0]               s_ms_id;
    logic                              s_sm_valid;
    logic                              s_sm_taken;
    logic [DATA_WIDTH-1:0]             s_sm_data;
    logic [ID_WIDTH-1:0]               s_sm_id;
    logic                              id_error;

    // Arbiter's view: consumes master requests and slave responses.
    modport slave (
        input  m_ms_valid, m_ms_address, m_ms_data, m_ms_write, m_sm_taken,
               s_ms_taken, s_sm_valid, s_sm_data, s_sm_id,
        output m_ms_taken, m_sm_valid, m_sm_data,
               s_ms_valid, s_ms_address, s_ms_data, s_ms_write, s_ms_id,
               s_sm_taken, id_error
    );

    // Environment's view: drives requests and slave responses.
    modport master (
        output m_ms_valid, m_ms_address, m_ms_data, m_ms_write, m_sm_taken,
               s_ms_taken, s_sm_valid, s_sm_data, s_sm_id,
        input  m_ms_taken, m_sm_valid, m_sm_data,
               s_ms_valid, s_ms_address, s_ms_data, s_ms_write, s_ms_id,
               s_sm_taken, id_error
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - round-robin arbiter sharing one memory slave port with per-master read caps
module memory_bus_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                 clock,
    input logic                 reset,
    memory_bus_arbiter_if.slave bus
);
    localparam int                  IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [ID_WIDTH-1:0] NM_ID    = ID_WIDTH'(NUM_MASTERS);
    localparam logic [3:0]          MAX_CNT  = 4'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       rr_last;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       cand;
    logic                   any_elig;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] inc_vec;
    logic [NUM_MASTERS-1:0] dec_vec;
    logic [3:0]             out_cnt [NUM_MASTERS];
    logic                   id_ok;
    logic                   req_fire;
    logic                   rsp_fire;
    logic [IDX_W-1:0]       rsp_idx;

    assign id_ok    = (bus.s_sm_id < NM_ID);
    assign rsp_idx  = bus.s_sm_id[IDX_W-1:0];
    assign req_fire = (state == HOLD) && bus.s_ms_taken;
    assign rsp_fire = bus.s_sm_valid && id_ok && bus.m_sm_taken[rsp_idx];

    assign bus.s_ms_valid = (state == HOLD);
    assign bus.m_sm_data  = bus.s_sm_data;

    // Writes are always eligible; reads only while the master is under its outstanding cap.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++)
            eligible[i] = bus.m_ms_valid[i] && (bus.m_ms_write[i] || (out_cnt[i] < MAX_CNT));
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        any_elig = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_W'((int'(rr_last) + k) % NUM_MASTERS);
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                winner   = cand;
            end
        end
    end

    // FSM next state and the combinational grant strobe back to the winning master.
    always_comb begin
        state_nxt      = state;
        bus.m_ms_taken = '0;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    bus.m_ms_taken[winner] = 1'b1;
                    state_nxt              = HOLD;
                end
            end
            HOLD: begin
                if (bus.s_ms_taken)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register; async reset drops s_ms_valid immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Capture the granted request toward the slave and remember the winner for fairness.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.s_ms_address <= '0;
            bus.s_ms_data    <= '0;
            bus.s_ms_write   <= 1'b0;
            bus.s_ms_id      <= '0;
            rr_last          <= LAST_IDX;
        end else if (state == IDLE && any_elig) begin
            bus.s_ms_address <= bus.m_ms_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.s_ms_data    <= bus.m_ms_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            bus.s_ms_write   <= bus.m_ms_write[winner];
            bus.s_ms_id      <= ID_WIDTH'(winner);
            rr_last          <= winner;
        end
    end

    // Route the slave response to the master named by its ID; bad IDs are swallowed.
    always_comb begin
        bus.m_sm_valid = '0;
        bus.s_sm_taken = 1'b1;
        if (id_ok) begin
            bus.m_sm_valid[rsp_idx] = bus.s_sm_valid;
            bus.s_sm_taken          = bus.m_sm_taken[rsp_idx];
        end
    end

    // Per-master increment on accepted reads and decrement on delivered responses.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            inc_vec[i] = req_fire && !bus.s_ms_write && (bus.s_ms_id == ID_WIDTH'(i));
            dec_vec[i] = rsp_fire && (rsp_idx == IDX_W'(i));
        end
    end

    // Outstanding-read counters; a stray decrement at zero saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MASTERS; i++)
                out_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10:   out_cnt[i] <= out_cnt[i] + 4'd1;
                    2'b01:   if (out_cnt[i] != 4'd0) out_cnt[i] <= out_cnt[i] - 4'd1;
                    default: out_cnt[i] <= out_cnt[i];
                endcase
            end
        end
    end

    // Sticky flag for responses addressed to a non-existent master.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            bus.id_error <= 1'b0;
        else if (bus.s_sm_valid && !id_ok)
            bus.id_error <= 1'b1;
    end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb/tb_memory_bus_arbiter.sv - scoreboard bench for memory_bus_arbiter
module tb_memory_bus_arbiter;
    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = 8;
    localparam int MAXO = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    memory_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    memory_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          write;
    } req_t;

    typedef struct packed {
        logic [N-1:0]  dest;
        logic [DW-1:0] data;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    req_t mon_req;
    rsp_t mon_rsp;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i * 16);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return 32'hCAFE_0000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_master(input int i, input logic v, input logic w);
        bus.m_ms_valid[i]            = v;
        bus.m_ms_write[i]            = w;
        bus.m_ms_address[i*AW +: AW] = addr_of(i);
        bus.m_ms_data[i*DW +: DW]    = data_of(i);
    endtask

    task automatic push_req(input int i, input logic w);
        req_t r;
        r.id    = IW'(i);
        r.addr  = addr_of(i);
        r.data  = data_of(i);
        r.write = w;
        exp_req.push_back(r);
    endtask

    task automatic push_rsp(input logic [N-1:0] dest, input logic [DW-1:0] d);
        rsp_t r;
        r.dest = dest;
        r.data = d;
        exp_rsp.push_back(r);
    endtask

    // Monitor: every slave-side request handshake and every master-side response handshake pops the scoreboard.
    always @(negedge clock) begin
        if (reset === 1'b1 && bus.s_ms_valid === 1'b1 && bus.s_ms_taken === 1'b1) begin
            if (exp_req.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL req_unexpected: got id %0d expected no request", bus.s_ms_id);
            end else begin
                mon_req = exp_req.pop_front();
                check("req_id",    64'(bus.s_ms_id),      64'(mon_req.id));
                check("req_addr",  64'(bus.s_ms_address), 64'(mon_req.addr));
                check("req_data",  64'(bus.s_ms_data),    64'(mon_req.data));
                check("req_write", 64'(bus.s_ms_write),   64'(mon_req.write));
            end
        end
        if (reset === 1'b1 && (bus.m_sm_valid & bus.m_sm_taken) != '0) begin
            if (exp_rsp.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: got dest %b expected no response", bus.m_sm_valid);
            end else begin
                mon_rsp = exp_rsp.pop_front();
                check("rsp_dest", 64'(bus.m_sm_valid), 64'(mon_rsp.dest));
                check("rsp_data", 64'(bus.m_sm_data),  64'(mon_rsp.data));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] e;
        reset            = 1'b0;
        bus.m_ms_valid   = '0;
        bus.m_ms_write   = '0;
        bus.m_ms_address = '0;
        bus.m_ms_data    = '0;
        bus.m_sm_taken   = '0;
        bus.s_ms_taken   = 1'b0;
        bus.s_sm_valid   = 1'b0;
        bus.s_sm_data    = '0;
        bus.s_sm_id      = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_s_ms_valid", 64'(bus.s_ms_valid),   64'd0);
        check("rst_m_ms_taken", 64'(bus.m_ms_taken),   64'd0);
        check("rst_s_ms_addr",  64'(bus.s_ms_address), 64'd0);
        check("rst_s_ms_id",    64'(bus.s_ms_id),      64'd0);
        check("rst_id_error",   64'(bus.id_error),     64'd0);
        reset = 1'b1;
        tick();

        // 1: all four masters write, slave always takes -> grants 0,1,2,3,0 every other cycle
        for (int i = 0; i < N; i++) set_master(i, 1'b1, 1'b1);
        bus.s_ms_taken = 1'b1;
        push_req(0, 1'b1); push_req(1, 1'b1); push_req(2, 1'b1); push_req(3, 1'b1); push_req(0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            e = (k % 2 == 0) ? N'(1 << ((k / 2) % N)) : '0;
            check("t1_grant", 64'(bus.m_ms_taken), 64'(e));
            tick();
        end
        bus.m_ms_valid = '0;

        // 2: master 2 alone issues reads; cap of 4 holds the 5th until a response drains one
        set_master(2, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) push_req(2, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            e = (k < 8 && k % 2 == 0) ? 4'b0100 : 4'b0000;
            check("t2_grant", 64'(bus.m_ms_taken), 64'(e));
            tick();
        end
        bus.s_sm_valid = 1'b1;
        bus.s_sm_id    = 8'd2;
        bus.s_sm_data  = 32'h1234_5678;
        bus.m_sm_taken = 4'b0100;
        push_rsp(4'b0100, 32'h1234_5678);
        @(negedge clock);
        check("t2_s_sm_taken", 64'(bus.s_sm_taken), 64'd1);
        tick();
        bus.s_sm_valid = 1'b0;
        bus.m_sm_taken = '0;
        @(negedge clock);
        check("t2_regrant", 64'(bus.m_ms_taken), 64'b0100);
        tick();
        @(negedge clock);
        check("t2_hold_valid", 64'(bus.s_ms_valid), 64'd1);
        check("t2_hold_id",    64'(bus.s_ms_id),    64'd2);
        tick();
        @(negedge clock);
        check("t2_capped", 64'(bus.m_ms_taken), 64'd0);
        bus.m_ms_valid = '0;
        tick();

        // 3: slave stalls five HOLD cycles; outputs stay put and nobody else is granted
        bus.s_ms_taken = 1'b0;
        set_master(1, 1'b1, 1'b1);
        push_req(1, 1'b1);
        @(negedge clock);
        check("t3_grant", 64'(bus.m_ms_taken), 64'b0010);
        tick();
        bus.m_ms_valid = 4'b0001;
        bus.m_ms_write = 4'b0001;
        bus.m_ms_address[1*AW +: AW] = 32'hFFFF_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("t3_hold_valid", 64'(bus.s_ms_valid),   64'd1);
            check("t3_hold_addr",  64'(bus.s_ms_address), 64'(addr_of(1)));
            check("t3_no_grant",   64'(bus.m_ms_taken),   64'd0);
            tick();
        end
        bus.s_ms_taken = 1'b1;
        bus.m_ms_valid = '0;
        @(negedge clock);
        check("t3_take_valid", 64'(bus.s_ms_valid), 64'd1);
        tick();
        @(negedge clock);
        check("t3_idle", 64'(bus.s_ms_valid), 64'd0);
        tick();

        // 4: response to master 1 routed, backpressure passes straight through
        bus.s_sm_valid = 1'b1;
        bus.s_sm_id    = 8'd1;
        bus.s_sm_data  = 32'hDEAD_BEEF;
        bus.m_sm_taken = '0;
        @(negedge clock);
        check("t4_m_sm_valid", 64'(bus.m_sm_valid), 64'b0010);
        check("t4_s_sm_taken", 64'(bus.s_sm_taken), 64'd0);
        check("t4_m_sm_data",  64'(bus.m_sm_data),  64'hDEAD_BEEF);
        tick();
        bus.m_sm_taken = 4'b0010;
        push_rsp(4'b0010, 32'hDEAD_BEEF);
        @(negedge clock);
        check("t4_s_sm_taken_1", 64'(bus.s_sm_taken), 64'd1);
        tick();
        bus.s_sm_valid = 1'b0;
        bus.m_sm_taken = '0;

        // 5: out-of-range ID is dropped and latches id_error
        bus.s_sm_valid = 1'b1;
        bus.s_sm_id    = 8'd7;
        bus.s_sm_data  = 32'h0000_0055;
        @(negedge clock);
        check("t5_s_sm_taken", 64'(bus.s_sm_taken), 64'd1);
        check("t5_m_sm_valid", 64'(bus.m_sm_valid), 64'd0);
        check("t5_err_before", 64'(bus.id_error),   64'd0);
        tick();
        bus.s_sm_valid = 1'b0;
        bus.s_sm_id    = 8'd0;
        @(negedge clock);
        check("t5_err_set", 64'(bus.id_error), 64'd1);
        tick();
        tick();
        @(negedge clock);
        check("t5_err_sticky", 64'(bus.id_error), 64'd1);
        tick();

        // 6: three reads from master 0, reset hits during the 4th HOLD
        set_master(0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) push_req(0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            e = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            check("t6_grant", 64'(bus.m_ms_taken), 64'(e));
            tick();
        end
        bus.s_ms_taken = 1'b0;
        @(negedge clock);
        check("t6_grant4", 64'(bus.m_ms_taken), 64'b0001);
        tick();
        @(negedge clock);
        check("t6_hold", 64'(bus.s_ms_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_drop", 64'(bus.s_ms_valid), 64'd0);
        check("t6_err_clear",  64'(bus.id_error),   64'd0);
        bus.m_ms_valid = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        bus.s_ms_taken = 1'b1;
        for (int i = 0; i < N; i++) set_master(i, 1'b1, 1'b1);
        push_req(0, 1'b1);
        @(negedge clock);
        check("t6_rr_restart", 64'(bus.m_ms_taken), 64'b0001);
        tick();
        bus.m_ms_valid = '0;
        set_master(0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) push_req(0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            e = (k % 2 == 1 && k <= 7) ? 4'b0001 : 4'b0000;
            check("t6_cnt_cleared", 64'(bus.m_ms_taken), 64'(e));
            tick();
        end
        bus.m_ms_valid = '0;
        repeat (3) tick();

        check("req_queue_drained", 64'(exp_req.size()), 64'd0);
        check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
